regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: req0_valid  in  1  requester 0 (ALU writeback) write request.
REQ-004 SHALL have port: req0_addr  in  5  requester 0 destination register.
REQ-005 SHALL have port: req0_data  in  32  requester 0 write data.
REQ-006 SHALL have port: req0_ready  out  1  requester 0 accept; handshake = valid & ready at rising edge.
REQ-007 SHALL have ports: req1_valid, req1_addr, req1_data, req1_ready, identical to REQ-003..006, for requester 1 (load writeback).
REQ-008 SHALL have port: regWrite  out  1  register-file write enable, registered.
REQ-009 SHALL have port: writeAddress  out  5  register-file write address, registered.
REQ-010 SHALL have port: writeInputData  out  32  register-file write data, registered.
REQ-011 SHALL have port: pending_mask  out  32  bit k = 1 while a write to register k is buffered or on the write port.
REQ-012 SHALL have parameter: none; all widths fixed as listed.

Function
REQ-013 SHALL hold one single-entry buffer per requester (full flag, addr, data).
REQ-014 SHALL drive reqN_ready = ~fullN | grantN; reqN_ready SHALL NOT depend combinationally on any valid input.
REQ-015 SHALL, on a handshake with addr != 0, load bufferN and set fullN on that edge.
REQ-016 SHALL, on a handshake with addr == 0, complete the handshake but leave bufferN empty; no write is ever issued to register 0.
REQ-017 SHALL grant combinationally from buffer state: only one full -> grant it; both full -> grant the requester not granted last; neither -> no grant.
REQ-018 SHALL keep a 1-bit last-grant pointer, updated to the granted index on every grant edge; unchanged when no grant.
REQ-019 SHALL, on a grant edge, copy the granted buffer into writeAddress/writeInputData, set regWrite = 1, and clear that buffer unless a new handshake on the same requester reloads it in the same edge.
REQ-020 SHALL drive regWrite = 0 in any cycle following an edge with no grant; writeAddress/writeInputData hold their last values.
REQ-021 Latency: handshake in cycle t, uncontested -> regWrite = 1 in cycle t+2; contested loser -> cycle t+3.
REQ-022 Throughput: SHALL sustain one write per cycle with requesters alternating or a single requester streaming.
REQ-023 SHALL issue writes in grant order only; two buffered writes to the same address are NOT merged; the later grant's data ends in the register file.
REQ-024 SHALL compute pending_mask combinationally as OR of decode(addr0) if full0, decode(addr1) if full1, decode(writeAddress) if regWrite; bit 0 is always 0.
REQ-025 SHALL never lose or duplicate an accepted non-zero write.

Reset
REQ-026 SHALL, while reset = 1 at a rising edge, clear full0, full1 and regWrite, zero writeAddress and writeInputData, and set last-grant pointer to 1 (requester 0 wins first tie).
REQ-027 SHALL drive req0_ready = req1_ready = 1 and pending_mask = 0 in the cycle after reset.
REQ-028 SHALL discard buffered and in-flight writes on reset asserted mid-operation; handshakes in a reset cycle are ignored.

Verification
REQ-029 Single write: req0 (addr 5, 0x37) one cycle -> regWrite = 1, writeAddress = 5, writeInputData = 0x37 exactly two cycles later; pending_mask = 0x20 for two cycles.
REQ-030 Collision: req0 (3, 0xA) and req1 (4, 0xB) same cycle after reset -> write (3, 0xA) at t+2, (4, 0xB) at t+3; req0_ready stays 1.
REQ-031 Round-robin: both requesters streaming continuously -> write port alternates 0,1,0,1 with regWrite = 1 every cycle; no starvation.
REQ-032 Register 0: req1 (0, 0xFF) -> handshake completes, regWrite stays 0, pending_mask stays 0.
REQ-033 Same address: req0 (7, 1) then req1 (7, 2) next cycle -> writes to 7 in order 1 then 2.
REQ-034 Reset mid-flight: both buffers full, reset one cycle -> next cycle regWrite = 0, pending_mask = 0, both readies = 1; no further writes issued.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the two writeback requesters and the
// register-file write arbiter, plus the registered write port it drives.
interface regfile_write_arbiter_if;
    // Requester 0 (ALU writeback)
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    // Requester 1 (load writeback)
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    // Register-file write port and hazard mask
    logic        regWrite;
    logic [4:0]  writeAddress;
    logic [31:0] writeInputData;
    logic [31:0] pending_mask;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  regWrite, writeAddress, writeInputData, pending_mask
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output regWrite, writeAddress, writeInputData, pending_mask
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter. Each requester owns a
// single-entry buffer; buffered writes are granted round-robin onto one
// registered write port. Writes to register 0 are accepted and dropped.
module regfile_write_arbiter (
    input  logic                           clk,
    input  logic                           reset,
    regfile_write_arbiter_if.slave         bus
);

    logic        full0_q, full0_d, full1_q, full1_d;
    logic [4:0]  addr0_q, addr0_d, addr1_q, addr1_d;
    logic [31:0] data0_q, data0_d, data1_q, data1_d;
    logic        last_q, last_d;              // index granted most recently
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_addr_q, write_addr_d;
    logic [31:0] write_data_q, write_data_d;

    logic        grant0, grant1;
    logic        ready0, ready1;
    logic        hs0, hs1;

    function automatic logic [31:0] decode(input logic [4:0] a);
        return 32'd1 << a;
    endfunction

    // Grant from buffer state only, so ready never depends on valid
    always_comb begin
        grant0 = full0_q & (~full1_q | last_q);
        grant1 = full1_q & (~full0_q | ~last_q);
        ready0 = ~full0_q | grant0;
        ready1 = ~full1_q | grant1;
        hs0    = bus.req0_valid & ready0;
        hs1    = bus.req1_valid & ready1;
    end

    // Next-state: buffer load/drain, write-port capture, pointer update
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch); blocking '=' is correct in combinational logic.
        full0_d      = full0_q;
        addr0_d      = addr0_q;
        data0_d      = data0_q;
        full1_d      = full1_q;
        addr1_d      = addr1_q;
        data1_d      = data1_q;
        last_d       = last_q;
        reg_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;

        // A reload in the same edge as a grant keeps the buffer full
        if (hs0 && bus.req0_addr != 5'd0) begin
            full0_d = 1'b1;
            addr0_d = bus.req0_addr;
            data0_d = bus.req0_data;
        end else if (grant0) begin
            full0_d = 1'b0;
        end

        if (hs1 && bus.req1_addr != 5'd0) begin
            full1_d = 1'b1;
            addr1_d = bus.req1_addr;
            data1_d = bus.req1_data;
        end else if (grant1) begin
            full1_d = 1'b0;
        end

        if (grant0) begin
            reg_write_d  = 1'b1;
            write_addr_d = addr0_q;
            write_data_d = data0_q;
            last_d       = 1'b0;
        end else if (grant1) begin
            reg_write_d  = 1'b1;
            write_addr_d = addr1_q;
            write_data_d = data1_q;
            last_d       = 1'b1;
        end
    end

    // Control and write-port state with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
        if (reset) begin
            full0_q      <= 1'b0;
            full1_q      <= 1'b0;
            last_q       <= 1'b1;
            reg_write_q  <= 1'b0;
            write_addr_q <= 5'd0;
            write_data_q <= 32'd0;
        end else begin
            full0_q      <= full0_d;
            full1_q      <= full1_d;
            last_q       <= last_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    // Buffer payloads; only meaningful while the matching full flag is set
    always_ff @(posedge clk) begin
        // NOTE: payload registers are deliberately not reset; the full flags alone decide validity.
        addr0_q <= addr0_d;
        data0_q <= data0_d;
        addr1_q <= addr1_d;
        data1_q <= data1_d;
    end

    // Drive interface outputs, including the pending-write hazard mask
    always_comb begin
        bus.req0_ready     = ready0;
        bus.req1_ready     = ready1;
        bus.regWrite       = reg_write_q;
        bus.writeAddress   = write_addr_q;
        bus.writeInputData = write_data_q;
        bus.pending_mask   = ((full0_q     ? decode(addr0_q)      : 32'd0) |
                              (full1_q     ? decode(addr1_q)      : 32'd0) |
                              (reg_write_q ? decode(write_addr_q) : 32'd0)) & ~32'd1;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = 5'd0;
        bus.req0_data  = 32'd0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 5'd0;
        bus.req1_data  = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"}, {31'd0, bus.regWrite}, {31'd0, we});
        if (we) begin
            check({tag, "_addr"}, {27'd0, bus.writeAddress}, {27'd0, a});
            check({tag, "_data"}, bus.writeInputData, d);
        end
    endtask

    initial begin
        int n0;
        int n1;
        logic hs0;
        logic hs1;
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        check("rst_rdy1", {31'd0, bus.req1_ready}, 32'd1);
        check("rst_mask", bus.pending_mask, 32'd0);
        check("rst_we", {31'd0, bus.regWrite}, 32'd0);
        check("rst_waddr", {27'd0, bus.writeAddress}, 32'd0);
        check("rst_wdata", bus.writeInputData, 32'd0);

        // Single write: (5, 0x37) appears two cycles later
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h37;
        check("single_rdy", {31'd0, bus.req0_ready}, 32'd1);
        step();
        idle_inputs();
        check_port("single_t1", 1'b0, 5'd0, 32'd0);
        check("single_mask_t1", bus.pending_mask, 32'h20);
        step();
        check_port("single_t2", 1'b1, 5'd5, 32'h37);
        check("single_mask_t2", bus.pending_mask, 32'h20);
        step();
        check("single_t3_we", {31'd0, bus.regWrite}, 32'd0);
        check("single_t3_mask", bus.pending_mask, 32'd0);
        check("single_hold_addr", {27'd0, bus.writeAddress}, 32'd5);
        check("single_hold_data", bus.writeInputData, 32'h37);

        // Collision right after reset: requester 0 wins the first tie
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'hB;
        step();
        idle_inputs();
        check("coll_rdy0_t1", {31'd0, bus.req0_ready}, 32'd1);
        check("coll_rdy1_t1", {31'd0, bus.req1_ready}, 32'd0);
        check("coll_mask_t1", bus.pending_mask, 32'h18);
        check_port("coll_t1", 1'b0, 5'd0, 32'd0);
        step();
        check_port("coll_t2", 1'b1, 5'd3, 32'hA);
        check("coll_rdy0_t2", {31'd0, bus.req0_ready}, 32'd1);
        check("coll_mask_t2", bus.pending_mask, 32'h18);
        step();
        check_port("coll_t3", 1'b1, 5'd4, 32'hB);
        check("coll_mask_t3", bus.pending_mask, 32'h10);
        step();
        check_port("coll_t4", 1'b0, 5'd0, 32'd0);

        // Round-robin streaming: writes alternate 0,1,0,1 every cycle from cycle 2
        do_reset();
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 12; c++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h100 + n0;
            bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h200 + n1;
            if (c >= 2) begin
                if (((c - 2) % 2) == 0)
                    check_port("rr", 1'b1, 5'd1, 32'h100 + (c - 2) / 2);
                else
                    check_port("rr", 1'b1, 5'd2, 32'h200 + (c - 3) / 2);
            end
            hs0 = bus.req0_ready;
            hs1 = bus.req1_ready;
            step();
            if (hs0) n0++;
            if (hs1) n1++;
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) step();
        check("rr_drained_mask", bus.pending_mask, 32'd0);

        // Register 0: handshake completes, nothing is written
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFF;
        check("r0_rdy", {31'd0, bus.req1_ready}, 32'd1);
        step();
        idle_inputs();
        check_port("r0_t1", 1'b0, 5'd0, 32'd0);
        check("r0_mask_t1", bus.pending_mask, 32'd0);
        check("r0_rdy_t1", {31'd0, bus.req1_ready}, 32'd1);
        step();
        check_port("r0_t2", 1'b0, 5'd0, 32'd0);
        check("r0_mask_t2", bus.pending_mask, 32'd0);

        // Same address from both requesters: issued in order 1 then 2
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'd1;
        step();
        idle_inputs();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'd2;
        check("same_mask_t1", bus.pending_mask, 32'h80);
        step();
        idle_inputs();
        check_port("same_t2", 1'b1, 5'd7, 32'd1);
        step();
        check_port("same_t3", 1'b1, 5'd7, 32'd2);
        step();
        check_port("same_t4", 1'b0, 5'd0, 32'd0);

        // Reset mid-flight with a handshake presented during the reset cycle
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd9;  bus.req0_data = 32'h99;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd10; bus.req1_data = 32'hAA;
        step();
        idle_inputs();
        check("mid_mask_full", bus.pending_mask, 32'h600);
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd11; bus.req0_data = 32'h11;
        step();
        reset = 1'b0;
        idle_inputs();
        check_port("mid_t1", 1'b0, 5'd0, 32'd0);
        check("mid_mask", bus.pending_mask, 32'd0);
        check("mid_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        check("mid_rdy1", {31'd0, bus.req1_ready}, 32'd1);
        step();
        check_port("mid_t2", 1'b0, 5'd0, 32'd0);
        check("mid_mask_t2", bus.pending_mask, 32'd0);
        step();
        check_port("mid_t3", 1'b0, 5'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
